// File: rtl/cr_fifo_sync_1c.sv
// cr_fifo_sync_1c: single-clock synchronous FIFO with private storage array.
// Occupancy counter, registered Full/Empty/AlmostFull/AlmostEmpty flags,
// sticky Overflow/Underflow, synchronous flush and a choice between a
// registered standard read port and a first-word-fall-through read port.
module cr_fifo_sync_1c #(
    parameter int pWidth    = 8,
    parameter int pAddrSize = 4,
    parameter int pFwft     = 0,
    parameter int pAfThresh = (1 << pAddrSize) - 2,
    parameter int pAeThresh = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Clr,
    input  logic                 WrEn,
    input  logic [pWidth-1:0]    WrData,
    input  logic                 RdEn,
    output logic [pWidth-1:0]    RdData,
    output logic                 RdValid,
    output logic                 Full,
    output logic                 Empty,
    output logic                 AlmostFull,
    output logic                 AlmostEmpty,
    output logic [pAddrSize:0]   Count,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int DEPTH = 1 << pAddrSize;

    // Thresholds and depth expressed at the counter width so every flag
    // comparison is a same-width unsigned compare.
    localparam logic [pAddrSize:0] DEPTH_C = DEPTH[pAddrSize:0];
    localparam logic [pAddrSize:0] AF_TH   = pAfThresh[pAddrSize:0];
    localparam logic [pAddrSize:0] AE_TH   = pAeThresh[pAddrSize:0];

    localparam bit PARAMS_OK = (pWidth >= 1) && (pAddrSize >= 1) &&
                               ((pFwft == 0) || (pFwft == 1)) &&
                               (pAfThresh >= 1) && (pAfThresh <= DEPTH) &&
                               (pAeThresh >= 0) && (pAeThresh <= DEPTH - 1);

    // Storage; contents are deliberately not reset.
    logic [pWidth-1:0]    mem [DEPTH];

    logic [pAddrSize-1:0] wptr_reg, wptr_next;
    logic [pAddrSize-1:0] rptr_reg, rptr_next;
    logic [pAddrSize:0]   count_reg, count_next;
    logic                 full_reg, full_next;
    logic                 empty_reg, empty_next;
    logic                 af_reg, af_next;
    logic                 ae_reg, ae_next;
    logic                 ovf_reg, ovf_next;
    logic                 unf_reg, unf_next;

    logic                 push_ok;
    logic                 pop_ok;

    // Acceptance uses the registered (pre-edge) Full/Empty, so a pop never
    // makes room for a same-cycle push and a push never feeds a same-cycle pop.
    always_comb begin
        push_ok = WrEn && !full_reg && !Clr;
        pop_ok  = RdEn && !empty_reg && !Clr;
    end

    // Next-state for pointers, occupancy, flags and sticky errors.
    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;

        if (Clr) begin
            // Flush wins over everything, including a same-cycle error set.
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
            ovf_next   = 1'b0;
            unf_next   = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_next = wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_next = rptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (WrEn && full_reg) begin
                ovf_next = 1'b1;
            end
            if (RdEn && empty_reg) begin
                unf_next = 1'b1;
            end
        end

        // Flags come from the next count so they line up with Count.
        full_next  = (count_next == DEPTH_C);
        empty_next = (count_next == '0);
        af_next    = (count_next >= AF_TH);
        ae_next    = (count_next <= AE_TH);
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            af_reg    <= 1'b0;
            ae_reg    <= 1'b1;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
            af_reg    <= af_next;
            ae_reg    <= ae_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Storage write port.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= WrData;
        end
    end

    generate
        if (pFwft == 0) begin : g_std
            logic [pWidth-1:0] rd_data_reg;
            logic              rd_valid_reg;

            // Registered read: data captured on the pop edge, valid for one cycle.
            // A flush clears RdValid but leaves the last word on RdData.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= pop_ok;
                    if (pop_ok) begin
                        rd_data_reg <= mem[rptr_reg];
                    end
                end
            end

            assign RdData  = rd_data_reg;
            assign RdValid = rd_valid_reg;
        end else begin : g_fwft
            // Head word is always presented; RdEn only acknowledges it.
            assign RdData  = mem[rptr_reg];
            assign RdValid = !empty_reg;
        end
    endgenerate

    assign Full        = full_reg;
    assign Empty       = empty_reg;
    assign AlmostFull  = af_reg;
    assign AlmostEmpty = ae_reg;
    assign Count       = count_reg;
    assign Overflow    = ovf_reg;
    assign Underflow   = unf_reg;

    // Parameter legality check for simulation.
    always @(posedge Clk) begin
        assert (PARAMS_OK)
        else $error("cr_fifo_sync_1c: illegal parameter combination");
    end

endmodule

// File: doc/cr_fifo_sync_1c.md
Name: cr_fifo_sync_1c

Overview:
Single-clock synchronous FIFO with its own dual-port storage array. It is the single-clock successor to the team's two-clock RAM, adding pointer management, occupancy count, full/empty and almost flags, sticky error flags, synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode. Intended for intra-domain buffering: bus bridges, stream elasticity, command queues.

Parameters:
pWidth, 8, data word width in bits (>=1)
pAddrSize, 4, address bits; DEPTH = 1<<pAddrSize entries (pAddrSize >= 1)
pFwft, 0, 0 = standard registered read; 1 = first-word-fall-through
pAfThresh, DEPTH-2, AlmostFull asserts when Count >= pAfThresh (1..DEPTH)
pAeThresh, 1, AlmostEmpty asserts when Count <= pAeThresh (0..DEPTH-1)

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally
Clr  input  1  synchronous flush; clears pointers, count and sticky flags
WrEn  input  1  push request
WrData  input  pWidth  push data
RdEn  input  1  pop request
RdData  output  pWidth  read data
RdValid  output  1  RdData holds a popped word (standard mode only)
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
AlmostFull  output  1  Count >= pAfThresh
AlmostEmpty  output  1  Count <= pAeThresh
Count  output  pAddrSize+1  current occupancy, 0..DEPTH
Overflow  output  1  sticky: a push was attempted while Full
Underflow  output  1  sticky: a pop was attempted while Empty

Behaviour:
- Reset (Rst_n=0, asynchronous): write and read pointers = 0; Count = 0; Empty = 1; Full = 0; AlmostEmpty = 1; AlmostFull = 0; Overflow = 0; Underflow = 0; RdValid = 0; standard-mode RdData register = 0. Memory contents are not reset.
- Push is accepted iff WrEn && !Full. When accepted, mem[wptr] <= WrData and wptr increments modulo DEPTH.
- Pop is accepted iff RdEn && !Empty. When accepted, rptr increments modulo DEPTH.
- Full and Empty are evaluated on the pre-edge state:
  - Push while Full is rejected even if a pop is accepted in the same cycle.
  - Pop while Empty is rejected even if a push is accepted in the same cycle.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- All flags (Full, Empty, AlmostFull, AlmostEmpty) are registered, derived from the next Count, and valid in the same cycle as Count.
- Pointers are pAddrSize bits and wrap naturally. Count is pAddrSize+1 bits, so Full is unambiguous.
- Error flags:
  - Overflow is set on WrEn && Full.
  - Underflow is set on RdEn && Empty.
  - Both hold until Clr or reset; Clr has priority over a same-cycle set.
- Clr=1: pointers, Count and sticky flags reset exactly as in reset; RdValid <= 0; any WrEn/RdEn in the same cycle is ignored. RdData register keeps its value.
- Standard mode (pFwft=0):
  - On an accepted pop, RdData <= mem[rptr] at that edge and RdValid = 1 for the following cycle, so read latency is 1 cycle.
  - RdValid = 0 in any cycle with no accepted pop on the previous edge; RdData holds its last value.
- FWFT mode (pFwft=1):
  - RdData = mem[rptr] combinationally and is valid whenever Empty = 0.
  - A word pushed into an empty FIFO is visible on RdData the cycle after the push edge, when Empty falls.
  - RdEn acts as an acknowledge; the next word (or don't-care if the FIFO becomes empty) appears the cycle after the pop edge.
  - RdValid is tied to !Empty.
- Write-to-read same-cycle bypass is not provided; a word is never readable in the cycle it is written.
- Parameter legality is checked with simulation-time assertions; synthesis behaviour for illegal values is undefined.

Test Plan:
1. pWidth=8, pAddrSize=2, pFwft=0. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> Count 1,2,3,4; Full=1 after 4th edge; AlmostFull=1 once Count>=2; Empty falls after 1st edge. Pop 4 times -> RdData 0x11..0x44 each with RdValid=1 one cycle after its pop; Empty=1 after 4th pop.
2. Full FIFO (depth 4). WrEn=1 with 0x55 and RdEn=1 in the same cycle -> push rejected, Overflow=1, Count=3; subsequent pops return 0x22, 0x33, 0x44, never 0x55.
3. Empty FIFO. RdEn=1 with WrEn=1 (0xA5) in the same cycle -> pop rejected, Underflow=1, Count=1, RdValid=0 next cycle. Next pop returns 0xA5.
4. Wrap-around. Repeat 10 rounds of push 3 / pop 3 with incrementing data -> output sequence matches input exactly; pointers wrap at 4 with no flag glitches; Count peaks at 3.
5. pFwft=1. Push 0x7E into empty FIFO -> next cycle Empty=0, RdData=0x7E with no RdEn. Pop with simultaneous push of 0x81 -> Count stays 1, RdData=0x81 next cycle.
6. Mid-operation flush and reset. Count=3 with Overflow=1, then Clr=1 with WrEn=1 -> Count=0, Empty=1, Overflow=0, the push is ignored. Rst_n pulsed low mid-cycle -> all outputs reach their reset values immediately, without waiting for a clock edge.
